vga_timing_gen: RTL

//  Raster timing source for the display path. Counts pixels and lines, and produces hsync, vsync and video_on.

---
 rtl/vga_timing_pkg.sv | 50 +++++
 rtl/vga_timing_gen_axis.sv | 49 ++++
 rtl/vga_timing_gen.sv | 139 +++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//   Shared timing constants for the raster generator:
//     - 800x600@72 Hz set (50 MHz pixel clock), used as the default
//     - 640x480@60 Hz alternative set (25.175 MHz pixel clock)
//     - 480x480 grid window placement (origin, cell edge, cell count)
//   Also provides the counter type and a half-open window compare helper.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

   localparam int CNT_W = 11;
   typedef logic [CNT_W-1:0] cnt_t;

   // 800x600@72, active-high syncs
   localparam int H_ACTIVE_800 = 800;
   localparam int H_FP_800     = 56;
   localparam int H_SYNC_800   = 120;
   localparam int H_BP_800     = 64;
   localparam int V_ACTIVE_800 = 600;
   localparam int V_FP_800     = 37;
   localparam int V_SYNC_800   = 6;
   localparam int V_BP_800     = 23;
   localparam bit H_POL_800    = 1'b1;
   localparam bit V_POL_800    = 1'b1;

   // 640x480@60, active-low syncs
   localparam int H_ACTIVE_640 = 640;
   localparam int H_FP_640     = 16;
   localparam int H_SYNC_640   = 96;
   localparam int H_BP_640     = 48;
   localparam int V_ACTIVE_640 = 480;
   localparam int V_FP_640     = 10;
   localparam int V_SYNC_640   = 2;
   localparam int V_BP_640     = 33;
   localparam bit H_POL_640    = 1'b0;
   localparam bit V_POL_640    = 1'b0;

   // Grid window: GRID_N x GRID_N cells of CELL pixels, placed in the
   // 800x600 active area.
   localparam int GRID_N       = 16;
   localparam int GRID_X0_DEF  = 231;
   localparam int GRID_Y0_DEF  = 36;
   localparam int CELL_DEF     = 30;

   // Half-open window test: lo <= c < hi
   function automatic logic in_window(input cnt_t c, input cnt_t lo, input cnt_t hi);
      return (c >= lo) && (c < hi);
   endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
//   One raster axis: counts 0..ACTIVE+FP+SYNC+BP-1 and decodes the region.
//   Region order is active, front porch, sync, back porch.
// Ports
//   clk       in   pixel-domain clock
//   rst_n     in   asynchronous active-low reset
//   en        in   advance the count this cycle
//   count     out  current position (11 bits)
//   active    out  count in [0, ACTIVE)
//   sync_raw  out  count in [ACTIVE+FP, ACTIVE+FP+SYNC), polarity-free
//   wrap      out  count is the last position; next enabled cycle returns to 0
// ---------------------------------------------------------------------------
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE = H_ACTIVE_800,
   parameter int FP     = H_FP_800,
   parameter int SYNC   = H_SYNC_800,
   parameter int BP     = H_BP_800
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output cnt_t count,
   output logic active,
   output logic sync_raw,
   output logic wrap
);

   localparam cnt_t LAST    = cnt_t'(ACTIVE + FP + SYNC + BP - 1);
   localparam cnt_t ACT_END = cnt_t'(ACTIVE);
   localparam cnt_t SYNC_LO = cnt_t'(ACTIVE + FP);
   localparam cnt_t SYNC_HI = cnt_t'(ACTIVE + FP + SYNC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (en)
         count <= wrap ? '0 : count + cnt_t'(1);
   end

   // wrap is combinational so the vertical axis can advance on the same
   // enabled cycle that the horizontal axis returns to 0.
   assign wrap     = (count == LAST);
   assign active   = (count < ACT_END);
   assign sync_raw = in_window(count, SYNC_LO, SYNC_HI);

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing source. Two axis counters produce (h,v); on every pxl_en
//   cycle the decode of the current (h,v) is registered to the outputs, so
//   all outputs share one enabled cycle of latency and hold while pxl_en=0.
// Ports
//   clk              in   pixel-domain clock
//   rst_n            in   asynchronous active-low reset
//   pxl_en           in   pixel strobe; nothing advances while low
//   hsync            out  horizontal sync, active level H_POL
//   vsync            out  vertical sync, active level V_POL
//   video_on         out  (h,v) inside the active area
//   on_screen_pxl_x  out  active x, 0 outside active columns
//   on_screen_pxl_y  out  active y, 0 outside active lines
//   line_start       out  pulse when h=0
//   frame_start      out  pulse when h=0, v=0
//   grid_active      out  inside the 16x16-cell grid window
//   frame_cnt        out  frames started since the first one, wraps at 256
// ---------------------------------------------------------------------------
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_800,
   parameter int H_FP     = H_FP_800,
   parameter int H_SYNC   = H_SYNC_800,
   parameter int H_BP     = H_BP_800,
   parameter int V_ACTIVE = V_ACTIVE_800,
   parameter int V_FP     = V_FP_800,
   parameter int V_SYNC   = V_SYNC_800,
   parameter int V_BP     = V_BP_800,
   parameter bit H_POL    = H_POL_800,
   parameter bit V_POL    = V_POL_800,
   parameter int GRID_X0  = GRID_X0_DEF,
   parameter int GRID_Y0  = GRID_Y0_DEF,
   parameter int CELL     = CELL_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pxl_en,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic [9:0] on_screen_pxl_x,
   output logic [9:0] on_screen_pxl_y,
   output logic       line_start,
   output logic       frame_start,
   output logic       grid_active,
   output logic [7:0] frame_cnt
);

   // Active area starts at count 0, so on-screen coordinates equal counts
   // and the grid bounds can be compared against the raw counters.
   localparam cnt_t GX_LO = cnt_t'(GRID_X0);
   localparam cnt_t GX_HI = cnt_t'(GRID_X0 + GRID_N * CELL);
   localparam cnt_t GY_LO = cnt_t'(GRID_Y0);
   localparam cnt_t GY_HI = cnt_t'(GRID_Y0 + GRID_N * CELL);

   cnt_t h_cnt, v_cnt;
   logic h_active, h_sync_raw, h_wrap;
   logic v_active, v_sync_raw, v_wrap;
   logic v_en;
   logic at_origin;
   logic in_grid;
   logic first_seen;   // first frame_start after reset has been presented

   assign v_en = pxl_en & h_wrap;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP)
   ) u_h (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (pxl_en),
      .count    (h_cnt),
      .active   (h_active),
      .sync_raw (h_sync_raw),
      .wrap     (h_wrap)
   );

   // v_wrap is unused at this level: both axes return to 0 together because
   // v only advances on h_wrap, and v's own wrap handles its rollover.
   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP)
   ) u_v (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (v_en),
      .count    (v_cnt),
      .active   (v_active),
      .sync_raw (v_sync_raw),
      .wrap     (v_wrap)
   );

   assign at_origin = (h_cnt == '0) && (v_cnt == '0);
   assign in_grid   = h_active && v_active &&
                      in_window(h_cnt, GX_LO, GX_HI) &&
                      in_window(v_cnt, GY_LO, GY_HI);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync           <= ~H_POL;
         vsync           <= ~V_POL;
         video_on        <= 1'b0;
         on_screen_pxl_x <= '0;
         on_screen_pxl_y <= '0;
         line_start      <= 1'b0;
         frame_start     <= 1'b0;
         grid_active     <= 1'b0;
         frame_cnt       <= '0;
         first_seen      <= 1'b0;
      end else if (pxl_en) begin
         hsync           <= h_sync_raw ? H_POL : ~H_POL;
         vsync           <= v_sync_raw ? V_POL : ~V_POL;
         video_on        <= h_active & v_active;
         on_screen_pxl_x <= h_active ? h_cnt[9:0] : '0;
         on_screen_pxl_y <= v_active ? v_cnt[9:0] : '0;
         line_start      <= (h_cnt == '0);
         frame_start     <= at_origin;
         grid_active     <= in_grid;
         // The frame presented straight out of reset is frame 0; only
         // later frame starts bump the counter.
         if (at_origin) begin
            if (first_seen)
               frame_cnt <= frame_cnt + 8'd1;
            first_seen <= 1'b1;
         end
      end
   end

   logic unused;
   assign unused = v_wrap;

endmodule
